// File: rtl/product_accumulator.sv
// Sums a programmed number of unsigned products into a wide accumulator and
// presents the total on a valid/ready result handshake.
module product_accumulator #(
    parameter int unsigned PW = 64,
    parameter int unsigned AW = 72,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic          in_valid,
    input  logic [PW-1:0] in_prod,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [CW-1:0] out_count,
    output logic          overflow,
    output logic          busy
);

    localparam int unsigned SW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    logic          accept_c;
    logic [SW-1:0] sum_c;

    assign accept_c = (state_q == ACCUM) && in_valid;
    // One extra bit captures the carry out of the accumulator width.
    assign sum_c    = SW'(acc_q) + SW'(in_prod);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept_c && (remaining_q == CW'(1))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs, decoded from the next state
    always_comb begin
        acc_d       = acc_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
        if ((state_q == IDLE) && start) begin
            acc_d       = '0;
            ovf_d       = 1'b0;
            count_d     = '0;
            remaining_d = len;
        end else if (accept_c) begin
            acc_d       = sum_c[AW-1:0];
            ovf_d       = ovf_q | sum_c[AW];
            count_d     = count_q + CW'(1);
            remaining_d = remaining_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = acc_q;
    assign out_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives two accumulators (72-bit and 65-bit result) with shared stimulus and
// checks both against an arbitrary-precision running total.
module tb_product_accumulator;

    localparam int unsigned PW  = 64;
    localparam int unsigned CW  = 8;
    localparam int unsigned AWA = 72;
    localparam int unsigned AWB = 65;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          in_valid;
    logic [PW-1:0] in_prod;
    logic          out_ready;

    logic           a_in_ready, a_out_valid, a_overflow, a_busy;
    logic [AWA-1:0] a_out_sum;
    logic [CW-1:0]  a_out_count;
    logic           b_in_ready, b_out_valid, b_overflow, b_busy;
    logic [AWB-1:0] b_out_sum;
    logic [CW-1:0]  b_out_count;

    int vectors = 0;
    int errors  = 0;

    logic [PW-1:0] prod_q[$];

    product_accumulator #(.PW(PW), .AW(AWA), .CW(CW)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_prod(in_prod), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
        .out_count(a_out_count), .overflow(a_overflow), .busy(a_busy)
    );

    product_accumulator #(.PW(PW), .AW(AWB), .CW(CW)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_prod(in_prod), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
        .out_count(b_out_count), .overflow(b_overflow), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete run of the products in prod_q; the expected result is the
    // exact integer total reduced modulo each accumulator width.
    task automatic run_one(input string tag, input int gap, input bit rnd_gap,
                           input int bp, input bit poke);
        int            n;
        int            g;
        logic [127:0]  total;
        logic [AWA-1:0] exp_a;
        logic [AWB-1:0] exp_b;
        logic          ovf_a, ovf_b;
        n     = prod_q.size();
        total = '0;
        start = 1'b1;
        len   = CW'(n);
        step();
        start = 1'b0;
        vectors++;
        if ({a_busy, b_busy} !== 2'b11) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b%b exp 11", tag, a_busy, b_busy);
        end
        for (int i = 0; i < n; i++) begin
            g = (i == 0) ? 0 : (rnd_gap ? $urandom_range(gap, 0) : gap);
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                if (poke) begin
                    start = 1'b1;
                    len   = CW'($urandom_range(9, 1));
                end
                step();
                start = 1'b0;
            end
            vectors++;
            if ({a_in_ready, b_in_ready, a_out_valid, b_out_valid} !== 4'b1100) begin
                errors++;
                $display("FAIL %s in_ready_term%0d: got rdy=%b%b vld=%b%b exp rdy=11 vld=00",
                         tag, i, a_in_ready, b_in_ready, a_out_valid, b_out_valid);
            end
            in_valid = 1'b1;
            in_prod  = prod_q[i];
            total    = total + 128'(prod_q[i]);
            step();
            in_valid = 1'b0;
        end
        exp_a = total[AWA-1:0];
        exp_b = total[AWB-1:0];
        ovf_a = |total[127:AWA];
        ovf_b = |total[127:AWB];
        vectors++;
        if ({a_out_valid, b_out_valid, a_in_ready, b_in_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL %s out_valid_latency: got vld=%b%b rdy=%b%b exp vld=11 rdy=00",
                     tag, a_out_valid, b_out_valid, a_in_ready, b_in_ready);
        end
        vectors++;
        if (a_out_sum !== exp_a || a_out_count !== CW'(n) || a_overflow !== ovf_a) begin
            errors++;
            $display("FAIL %s result_aw72: got sum=%0h cnt=%0d ovf=%b exp sum=%0h cnt=%0d ovf=%b",
                     tag, a_out_sum, a_out_count, a_overflow, exp_a, n, ovf_a);
        end
        vectors++;
        if (b_out_sum !== exp_b || b_out_count !== CW'(n) || b_overflow !== ovf_b) begin
            errors++;
            $display("FAIL %s result_aw65: got sum=%0h cnt=%0d ovf=%b exp sum=%0h cnt=%0d ovf=%b",
                     tag, b_out_sum, b_out_count, b_overflow, exp_b, n, ovf_b);
        end
        for (int k = 0; k < bp; k++) begin
            out_ready = 1'b0;
            if (poke) begin
                start    = 1'b1;
                len      = CW'($urandom_range(9, 0));
                in_valid = 1'b1;
                in_prod  = {$urandom, $urandom};
            end
            step();
            start    = 1'b0;
            in_valid = 1'b0;
            vectors++;
            if ({a_out_valid, b_out_valid} !== 2'b11 || a_out_sum !== exp_a
                || b_out_sum !== exp_b || a_out_count !== CW'(n)) begin
                errors++;
                $display("FAIL %s hold_stable_%0d: got vld=%b%b sum=%0h/%0h cnt=%0d exp vld=11 sum=%0h/%0h cnt=%0d",
                         tag, k, a_out_valid, b_out_valid, a_out_sum, b_out_sum, a_out_count,
                         exp_a, exp_b, n);
            end
        end
        out_ready = 1'b1;
        start     = poke;
        len       = CW'(3);
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        vectors++;
        if ({a_out_valid, b_out_valid, a_busy, b_busy, a_in_ready, b_in_ready} !== 6'b0
            || a_out_sum !== exp_a || b_out_sum !== exp_b || b_out_count !== CW'(n)) begin
            errors++;
            $display("FAIL %s idle_after_handshake: got vld=%b busy=%b rdy=%b sum=%0h/%0h cnt=%0d exp all 0, sum=%0h/%0h cnt=%0d",
                     tag, a_out_valid, a_busy, a_in_ready, a_out_sum, b_out_sum, b_out_count,
                     exp_a, exp_b, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if ({a_in_ready, a_out_valid, a_busy, a_overflow, b_in_ready, b_out_valid, b_busy, b_overflow} !== 8'b0
            || a_out_sum !== '0 || b_out_sum !== '0 || a_out_count !== '0 || b_out_count !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b ovf=%b sum=%0h cnt=%0d exp all 0",
                     a_in_ready, a_out_valid, a_busy, a_overflow, a_out_sum, a_out_count);
        end
    endtask

    task automatic test_basic();
        prod_q = '{64'd11682699, 64'd440788734381975};
        run_one("basic", 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_stall_backpressure();
        prod_q = '{64'd5, 64'd7, 64'd9};
        run_one("stall_bp", 1, 1'b0, 4, 1'b0);
    endtask

    task automatic test_overflow();
        prod_q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        run_one("overflow", 0, 1'b0, 1, 1'b0);
        vectors++;
        if (b_out_sum !== 65'h0_FFFF_FFFF_FFFF_FFFD || b_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_wrap65: got sum=%0h ovf=%b exp sum=fffffffffffffffd ovf=1",
                     b_out_sum, b_overflow);
        end
    endtask

    task automatic test_zero_len();
        prod_q = {};
        run_one("zero_len", 0, 1'b0, 2, 1'b0);
    endtask

    task automatic test_reset_abort();
        start = 1'b1;
        len   = CW'(3);
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_prod  = 64'd100;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({a_in_ready, a_out_valid, a_busy, a_overflow, b_in_ready, b_out_valid, b_busy, b_overflow} !== 8'b0
            || a_out_sum !== '0 || b_out_sum !== '0 || a_out_count !== '0 || b_out_count !== '0) begin
            errors++;
            $display("FAIL reset_abort: got rdy=%b vld=%b busy=%b sum=%0h cnt=%0d exp all 0",
                     a_in_ready, a_out_valid, a_busy, a_out_sum, a_out_count);
        end
        prod_q = '{64'd4};
        run_one("after_abort", 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_idle_drop();
        in_valid = 1'b1;
        in_prod  = 64'd55;
        step();
        in_valid = 1'b0;
        vectors++;
        if ({a_busy, a_in_ready, a_out_valid, b_busy} !== 4'b0) begin
            errors++;
            $display("FAIL idle_drop_state: got busy=%b rdy=%b vld=%b exp 000",
                     a_busy, a_in_ready, a_out_valid);
        end
        prod_q = '{64'd6};
        run_one("idle_drop", 0, 1'b0, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [PW-1:0] p;
        for (int r = 0; r < 20; r++) begin
            prod_q = {};
            n = $urandom_range(6, 0);
            for (int i = 0; i < n; i++) begin
                p = ($urandom_range(3, 0) == 0) ? {PW{1'b1}} : {$urandom, $urandom};
                prod_q.push_back(p);
            end
            run_one("random", 2, 1'b1, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall_backpressure();
        test_overflow();
        test_zero_len();
        test_reset_abort();
        test_idle_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
